spi_controller: RTL and testbench

// - SPI initiator (controller): generates SCLK edges, drives CS_N/MOSI, samples MISO.
// - One DATA_W-bit full-duplex word per start request; SPI modes 0-3 via cpol/cpha.
// - Sits on the system side of the chip opposite an SPI peripheral.
// - Used to drive and loop-check the SPI peripheral wrapper.

---
 rtl/spi_controller.sv | 186 ++++++++++++++++++
 tb/tb_spi_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI initiator: one DATA_W-bit full-duplex word per start, modes 0-3; `SPI_CTRL_LSB_FIRST_EN adds lsb_first.
// Latency: busy for (2*DATA_W+2)*(clk_div+1) enabled cycles, done pulses in the first IDLE cycle after.
// Backpressure: none; ena=0 freezes everything, start while busy is dropped.
module spi_controller #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 start,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic                 cpol,
    input  logic                 cpha,
`ifdef SPI_CTRL_LSB_FIRST_EN
    input  logic                 lsb_first,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CLK_DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]      rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [CLK_DIV_W-1:0]   clk_div_q, clk_div_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick, leading, sample_edge, last_edge;
    logic                   lsb_start, lsb_sel;

`ifdef SPI_CTRL_LSB_FIRST_EN
    logic lsb_first_q;
    always_ff @(posedge clk) begin
        if (!rstb) begin
            lsb_first_q <= 1'b0;
        end else if (ena && state_q == IDLE && start) begin
            lsb_first_q <= lsb_first;
        end
    end
    assign lsb_start = lsb_first;
    assign lsb_sel   = lsb_first_q;
`else
    assign lsb_start = 1'b0;
    assign lsb_sel   = 1'b0;
`endif

    assign tick        = (div_cnt_q == clk_div_q);
    // edge_cnt_q counts completed edges, so an even count means the coming edge is a leading one
    assign leading     = ~edge_cnt_q[0];
    assign sample_edge = leading ^ cpha_q;
    assign last_edge   = (edge_cnt_q == EDGE_W'(2 * DATA_W - 1));

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        clk_div_d  = clk_div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (state_q != IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                sclk_d     = cpol;
                div_cnt_d  = '0;
                edge_cnt_d = '0;
                if (start) begin
                    state_d   = SETUP;
                    clk_div_d = clk_div;
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    rx_sr_d   = '0;
                    tx_sr_d   = tx_data;
                    // cpha=0 needs the first bit on the wire before the first (sampling) edge
                    if (!cpha) begin
                        mosi_d  = lsb_start ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sr_d = lsb_start ? (tx_data >> 1) : (tx_data << 1);
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (sample_edge) begin
                        rx_sr_d = lsb_sel ? {miso, rx_sr_q[DATA_W-1:1]}
                                          : {rx_sr_q[DATA_W-2:0], miso};
                    end else if (!last_edge) begin
                        mosi_d  = lsb_sel ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
                        tx_sr_d = lsb_sel ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                    end
                    if (last_edge) begin
                        state_d    = HOLD;
                        edge_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            clk_div_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            clk_div_q  <= clk_div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: an SPI peripheral model feeds miso, a per-cycle observer rebuilds the transfer.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rstb, ena, start, cpol, cpha;
    logic [7:0] tx_data, clk_div;
    logic       busy, done, sclk, cs_n, mosi, miso;
    logic [7:0] rx_data;
    logic       miso_bit, loop_en;

    int checks = 0;
    int failures = 0;

    // observer results
    int         m_busy, m_edges, m_bad_intv, m_frozen_bad, m_samples;
    logic [7:0] m_mosi, m_rx;
    logic       m_done, m_cs_first, m_cs_at_done, m_sclk_end;
    int         chg_at = -1;
    logic [7:0] chg_val;

    assign miso = loop_en ? mosi : miso_bit;

    spi_controller #(.DATA_W(8), .CLK_DIV_W(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .tx_data(tx_data),
        .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .busy(busy), .done(done),
        .rx_data(rx_data), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [7:0] tx, input logic pol, input logic pha,
                          input logic [7:0] div, input logic lp);
        tx_data = tx; cpol = pol; cpha = pha; clk_div = div; loop_en = lp; start = 1'b1;
    endtask

    // Peripheral + observer: presents pat MSB first, records mosi at the sample edge of the mode.
    task automatic observe(input logic pol, input logic pha, input int div, input logic [7:0] pat,
                           input logic keep_start, input int freeze_at);
        logic       prev_sclk;
        logic [3:0] snap;
        int         last_cyc, frz;
        prev_sclk = pol; last_cyc = -1; frz = 0; snap = '0;
        m_busy = 0; m_edges = 0; m_bad_intv = 0; m_frozen_bad = 0; m_samples = 0;
        m_mosi = '0; m_rx = '0; m_done = 1'b0; m_cs_first = 1'b1; m_cs_at_done = 1'b0; m_sclk_end = 1'b0;
        miso_bit = pat[7];
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (!keep_start) start = 1'b0;
                m_cs_first = cs_n;
            end
            if (cyc == chg_at) tx_data = chg_val;
            if (busy === 1'b1) m_busy++;
            if (frz > 0) begin
                if ({sclk, cs_n, mosi, busy} !== snap) m_frozen_bad++;
                frz--;
                if (frz == 0) ena = 1'b1;
            end else if (cyc == freeze_at) begin
                snap = {sclk, cs_n, mosi, busy};
                ena = 1'b0;
                frz = 5;
            end
            if (sclk !== prev_sclk) begin
                m_edges++;
                if (last_cyc >= 0 && freeze_at < 0 && (cyc - last_cyc) != div + 1) m_bad_intv++;
                last_cyc = cyc;
                // modes 0/3 sample on rising sclk, modes 1/2 on falling
                if (sclk === ~(pol ^ pha)) begin
                    m_mosi = {m_mosi[6:0], mosi};
                    m_samples++;
                    if (m_samples < 8) miso_bit = pat[7 - m_samples];
                end
            end
            prev_sclk = sclk;
            if (done === 1'b1) begin
                m_done = 1'b1; m_rx = rx_data; m_cs_at_done = cs_n; m_sclk_end = sclk;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL observe_timeout: no done within 3000 cycles");
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
        clk_div = '0; loop_en = 1'b0; miso_bit = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, cs_n, sclk, mosi} !== 5'b00100) begin
            failures++; $display("FAIL reset_ctrl: busy,done,cs_n,sclk,mosi=%b want 00100", {busy, done, cs_n, sclk, mosi});
        end
        checks++; if (rx_data !== 8'h00) begin
            failures++; $display("FAIL reset_rx: got %h want 00", rx_data);
        end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        launch(8'hA5, 1'b0, 1'b0, 8'd0, 1'b0);
        observe(1'b0, 1'b0, 0, 8'h3C, 1'b0, -1);
        checks++; if (m_mosi !== 8'hA5) begin failures++; $display("FAIL mode0_mosi: got %h want a5", m_mosi); end
        checks++; if (m_busy != 18) begin failures++; $display("FAIL mode0_busy: got %0d want 18", m_busy); end
        checks++; if (m_rx !== 8'h3C) begin failures++; $display("FAIL mode0_rx: got %h want 3c", m_rx); end
        checks++; if (m_edges != 16 || m_bad_intv != 0) begin
            failures++; $display("FAIL mode0_sclk: edges %0d bad_intervals %0d want 16/0", m_edges, m_bad_intv);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || rx_data !== 8'h3C) begin
            failures++; $display("FAIL mode0_done_pulse: done %b rx %h want 0/3c", done, rx_data);
        end
    endtask

    task automatic test_mode3();
        cpol = 1'b1; cpha = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL mode3_idle_sclk: got %b want 1", sclk); end
        launch(8'h81, 1'b1, 1'b1, 8'd3, 1'b0);
        observe(1'b1, 1'b1, 3, 8'hFF, 1'b0, -1);
        checks++; if (m_busy != 72) begin failures++; $display("FAIL mode3_busy: got %0d want 72", m_busy); end
        checks++; if (m_rx !== 8'hFF) begin failures++; $display("FAIL mode3_rx: got %h want ff", m_rx); end
        checks++; if (m_mosi !== 8'h81) begin failures++; $display("FAIL mode3_mosi: got %h want 81", m_mosi); end
        checks++; if (m_bad_intv != 0 || m_edges != 16 || m_sclk_end !== 1'b1) begin
            failures++; $display("FAIL mode3_sclk: bad_intervals %0d edges %0d end %b want 0/16/1", m_bad_intv, m_edges, m_sclk_end);
        end
    endtask

    task automatic test_mode12_loop();
        for (int m = 0; m < 2; m++) begin
            logic pol;
            pol = (m == 1);
            launch(8'h5A, pol, ~pol, 8'd1, 1'b1);
            observe(pol, ~pol, 1, 8'h00, 1'b0, -1);
            loop_en = 1'b0;
            checks++; if (m_rx !== 8'h5A) begin failures++; $display("FAIL loop_mode%0d_rx: got %h want 5a", m + 1, m_rx); end
            checks++; if (m_edges != 16 || m_sclk_end !== pol) begin
                failures++; $display("FAIL loop_mode%0d_sclk: edges %0d end %b want 16/%b", m + 1, m_edges, m_sclk_end, pol);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx1, tx2, pat1, pat2;
        int bad;
        tx1 = 8'($urandom); tx2 = 8'($urandom); pat1 = 8'($urandom); pat2 = 8'($urandom);
        launch(tx1, 1'b0, 1'b0, 8'd0, 1'b0);
        chg_at = 4; chg_val = tx2;
        observe(1'b0, 1'b0, 0, pat1, 1'b1, -1);
        chg_at = -1;
        checks++; if (m_busy != 18 || m_mosi !== tx1 || m_rx !== pat1) begin
            failures++; $display("FAIL b2b_first: busy %0d mosi %h rx %h want 18/%h/%h", m_busy, m_mosi, m_rx, tx1, pat1);
        end
        checks++; if (m_cs_at_done !== 1'b1) begin failures++; $display("FAIL b2b_cs_gap: got %b want 1", m_cs_at_done); end
        observe(1'b0, 1'b0, 0, pat2, 1'b0, -1);
        checks++; if (m_cs_first !== 1'b0) begin failures++; $display("FAIL b2b_cs_fall: got %b want 0", m_cs_first); end
        checks++; if (m_busy != 18 || m_mosi !== tx2 || m_rx !== pat2) begin
            failures++; $display("FAIL b2b_second: busy %0d mosi %h rx %h want 18/%h/%h", m_busy, m_mosi, m_rx, tx2, pat2);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || cs_n !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_no_third: %0d busy cycles want 0", bad); end
    endtask

    task automatic test_ena_freeze();
        logic [7:0] tx, pat;
        tx = 8'($urandom); pat = 8'($urandom);
        launch(tx, 1'b0, 1'b0, 8'd1, 1'b0);
        observe(1'b0, 1'b0, 1, pat, 1'b0, 10);
        checks++; if (m_frozen_bad != 0) begin failures++; $display("FAIL freeze_outputs: %0d changed cycles want 0", m_frozen_bad); end
        checks++; if (m_busy != 41) begin failures++; $display("FAIL freeze_busy: got %0d want 41", m_busy); end
        checks++; if (m_rx !== pat || m_mosi !== tx) begin
            failures++; $display("FAIL freeze_data: rx %h mosi %h want %h/%h", m_rx, m_mosi, pat, tx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic       pol, pha, lp;
            logic [7:0] tx, pat, exp_rx;
            int         div;
            pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1)); lp = 1'($urandom_range(0, 1));
            div = int'($urandom_range(0, 3));
            tx = 8'($urandom); pat = 8'($urandom);
            exp_rx = lp ? tx : pat;
            launch(tx, pol, pha, 8'(div), lp);
            observe(pol, pha, div, pat, 1'b0, -1);
            loop_en = 1'b0;
            checks++; if (m_busy != 18 * (div + 1)) begin
                failures++; $display("FAIL random%0d_busy: got %0d want %0d", i, m_busy, 18 * (div + 1));
            end
            checks++; if (m_rx !== exp_rx || m_mosi !== tx) begin
                failures++; $display("FAIL random%0d_data: rx %h mosi %h want %h/%h", i, m_rx, m_mosi, exp_rx, tx);
            end
            checks++; if (m_edges != 16 || m_bad_intv != 0 || m_sclk_end !== pol) begin
                failures++; $display("FAIL random%0d_sclk: edges %0d bad %0d end %b want 16/0/%b", i, m_edges, m_bad_intv, m_sclk_end, pol);
            end
        end
    endtask

    task automatic test_rstb_abort();
        logic prev;
        int   e, bad;
        launch(8'($urandom), 1'b0, 1'b0, 8'd0, 1'b0);
        miso_bit = 1'b1;
        prev = 1'b0; e = 0;
        for (int cyc = 0; cyc < 200 && e < 7; cyc++) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            if (sclk !== prev) e++;
            prev = sclk;
        end
        checks++; if (e != 7) begin failures++; $display("FAIL abort_reach_edge7: got %0d edges want 7", e); end
        rstb = 1'b0;
        @(negedge clk);
        checks++; if ({cs_n, sclk, busy, done} !== 4'b1000 || rx_data !== 8'h00) begin
            failures++; $display("FAIL abort_state: cs_n,sclk,busy,done=%b rx %h want 1000/00", {cs_n, sclk, busy, done}, rx_data);
        end
        rstb = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_no_done: %0d bad cycles want 0", bad); end
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
        clk_div = '0; loop_en = 1'b0; miso_bit = 1'b0; chg_val = '0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_mode3();
        test_mode12_loop();
        test_back_to_back();
        test_ena_freeze();
        test_random();
        test_rstb_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
